// File: rtl/div32_iter.sv
// div32_iter: iterative 32-bit restoring divider (DIV/DIVU), one step per clock.
// Ports: clk, rst (sync high), start/is_signed/dividend/divisor in; busy, done, quotient, remainder, div_zero out.
module div32_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t      state;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic        q_neg;
  logic        r_neg;
  logic        dz;

  logic [32:0] rem_sh;
  logic [33:0] trial;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  // quo starts as the dividend magnitude and fills with quotient bits
  // from the bottom as dividend bits leave through the top.
  always_comb begin
    rem_sh = {rem[31:0], quo[31]};
    trial  = {rem, quo[31]} - {2'b0, dvs};
    mag_a  = (is_signed && dividend[31]) ? -dividend : dividend;
    mag_b  = (is_signed && divisor[31])  ? -divisor  : divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            q_neg <= is_signed & (dividend[31] ^ divisor[31]);
            r_neg <= is_signed & dividend[31];
            dvs   <= mag_b;
            if (divisor == 32'd0) begin
              // raw dividend kept so it comes back unchanged
              rem   <= {1'b0, dividend};
              quo   <= '1;
              dz    <= 1'b1;
              state <= FIX;
            end else begin
              rem   <= '0;
              quo   <= mag_a;
              dz    <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (trial[33]) begin
            rem <= rem_sh;
            quo <= {quo[30:0], 1'b0};
          end else begin
            rem <= trial[32:0];
            quo <= {quo[30:0], 1'b1};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            quotient  <= quo;
            remainder <= rem[31:0];
          end else begin
            quotient  <= q_neg ? -quo : quo;
            remainder <= r_neg ? -rem[31:0] : rem[31:0];
          end
          div_zero <= dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_iter.sv
// tb_div32_iter: directed bench for div32_iter with a
// latency/arithmetic reference model and per-cycle compare.
module tb_div32_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int total  = 0;
  int passed = 0;

  div32_iter dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // {dz, quotient, remainder} from plain truncating arithmetic
  function automatic logic [64:0] model(input logic s,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, lq, lr;
    logic [63:0] uq, ur;
    if (b == 32'd0) return {1'b1, 32'hFFFFFFFF, a};
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    lq = sa / sb;
    lr = sa % sb;
    uq = lq;
    ur = lr;
    return {1'b0, uq[31:0], ur[31:0]};
  endfunction

  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_q, m_r;
  logic [64:0] m_pend;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_dz    <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_dz, m_q, m_r} <= m_pend;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_left <= (divisor == 32'd0) ? 1 : 33;
        m_pend <= model(is_signed, dividend, divisor);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid)
      check("cycle", {busy, done, div_zero, quotient, remainder},
            {m_busy, m_done, m_dz, m_q, m_r});
  end

  task automatic do_op(input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq,
                       input logic [31:0] er, input logic ez,
                       input int lat, input int glitch, input int ebusy);
    int n, nb;
    @(negedge clk);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(negedge clk);
    n = 1; nb = 0;
    start = 1'b0; is_signed = ~s;
    dividend = $urandom; divisor = $urandom;
    while (!done && n < 100) begin
      start = (n == glitch);
      if (start) begin
        is_signed = 1'b0; dividend = 32'd1; divisor = 32'd1;
      end
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, ez);
    if (ebusy > 0) check("busy_cycles", nb, ebusy);
  endtask

  task automatic held_op();
    int n;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    n = 1;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("held_lat1", n, 34);
    check("held_q1", quotient, 32'd14);
    dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("held_busy2", busy, 1'b1);
    n = 1;
    while (!done && n < 100) begin
      if (n == 20) check("held_hold_q", quotient, 32'd14);
      @(negedge clk);
      n++;
    end
    check("held_lat2", n, 34);
    check("held_q2", quotient, 32'd3);
    check("held_r2", remainder, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset", {busy, done, div_zero, quotient, remainder}, 128'd0);

    check("model_neg7_2", model(1'b1, 32'hFFFFFFF9, 32'd2),
          {1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF});
    check("model_ovf", model(1'b1, 32'h80000000, 32'hFFFFFFFF),
          {1'b0, 32'h80000000, 32'h0});
    check("model_dz", model(1'b0, 32'h12345678, 32'h0),
          {1'b1, 32'hFFFFFFFF, 32'h12345678});

    do_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34, 0, 33);
    do_op(1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 34, 0, 0);
    do_op(1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 34, 0, 0);
    do_op(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0, 34, 0, 0);
    do_op(0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 34, 0, 0);
    do_op(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 34, 0, 0);
    do_op(0, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd5, 0, 34, 0, 0);
    do_op(1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1, 2, 0, 1);
    do_op(0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 34, 0, 0);
    do_op(1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 2, 0, 0);
    do_op(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34, 5, 0);

    held_op();

    @(negedge clk);
    start = 1'b1; is_signed = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort", {busy, done, div_zero, quotient, remainder}, 128'd0);
    do_op(0, 32'd20, 32'd6, 32'd3, 32'd2, 0, 34, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div32_iter.md
# div32_iter

Iterative 32-bit integer divider for the EX stage, alongside the 33-bit add/subtract adder. It accepts a dividend/divisor pair on a start pulse and runs one restoring-division step per clock using a widened two's-complement trial subtract. It returns quotient (LO) and remainder (HI) with a one-cycle done pulse, and the pipeline stalls on busy while it runs. It covers MIPS DIV (signed) and DIVU (unsigned).

## Interface
- none (width fixed at 32)

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- dividend  in  32  sampled with start
- divisor  in  32  sampled with start
- busy  out  1  high from the edge accepting start until the edge producing done
- done  out  1  one-cycle pulse; quotient/remainder/div_zero valid from this cycle
- quotient  out  32  LO result; holds until the next done
- remainder  out  32  HI result; holds until the next done
- div_zero  out  1  divisor was 0 for the completed op; holds with results

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start:
  - Latch the operand magnitudes: in signed mode, negate if bit 31 = 1; -2^31 maps to magnitude 2^31 unsigned.
  - Latch q_neg = is_signed & (dividend[31] ^ divisor[31]) and r_neg = is_signed & dividend[31].
  - Clear the partial remainder (33 bits) and the step counter (6 bits).
  - Go to CALC; if divisor == 0, go straight to FIX with the dz flag set.
- CALC, per cycle:
  - Shift {rem, quo} left 1 bit, bringing in the next dividend magnitude bit MSB-first.
  - Trial: t = {1'b0, rem_shifted} - {2'b0, divisor_mag}, computed 34 bits wide.
  - If t[33] = 0: rem = t, quotient bit = 1. Otherwise keep rem_shifted, quotient bit = 0.
  - Counter increments; after the 32nd step, go to FIX.
- FIX (one cycle):
  - quotient = q_neg ? -quo : quo; remainder = r_neg ? -rem : rem (32-bit wrap).
  - div_zero = dz; done = 1; go to IDLE.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = dividend unchanged, div_zero = 1. Sign fix is not applied.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0, div_zero = 0. This falls out of the magnitude path; no special case.
- Remainder always carries the dividend's sign (truncating division), and |remainder| < |divisor|.

## Timing
- Reset (rst high at an edge): state IDLE; busy, done, div_zero = 0; quotient = remainder = 0; counter and internal registers cleared.
- Reset mid-operation aborts: no done, outputs return to 0, next start is accepted normally.
- Edge E0 accepts start; busy = 1 from E0.
- Normal op: CALC on E1..E32, FIX on E33. done is high for the single cycle following E33, and busy falls at E33. Latency start→done = 34 cycles.
- Divide-by-zero op: FIX on E1, done in the cycle after E1 (latency 2).
- start while busy is ignored; operands are not re-sampled.
- start in the cycle where done = 1 is accepted, since the state is IDLE; back-to-back throughput is one op per 34 cycles.
- Operand inputs may change freely after E0.
- Outputs change only at the FIX edge or at reset.

## Test plan
- DIVU 100 / 7: start at E0 → done exactly 34 cycles later with quotient = 14, remainder = 2, div_zero = 0; busy high for 33 cycles.
- DIV 0xFFFFFFF9 (-7) / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Also 7 / 0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 1.
- Extremes:
  - DIVU 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
  - DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
  - DIVU 5 / 0xFFFFFFFF → quotient 0, remainder 5.
- Divide by zero: DIV 0x12345678 / 0 → done 2 cycles after start; quotient 0xFFFFFFFF, remainder 0x12345678, div_zero 1. A following DIVU 9 / 3 clears div_zero and gives quotient 3, remainder 0.
- Handshake:
  - start pulsed again at E5 with different operands → ignored; the first result is unchanged.
  - start held high across done → second op begins; results hold until its own done.
- rst asserted 10 cycles into an op → next cycle busy = 0, done = 0, outputs 0; a fresh DIVU 20 / 6 completes with quotient 3, remainder 2 in 34 cycles.
